// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder
//   Decodes framed command bytes arriving as one-cycle rx_valid strobes into
//   register-file read/write strobes and ALU execute strobes.
//
//   Frames (first byte is the command):
//     0xAA addr data      register write
//     0xBB addr           register read
//     0xCC opA opB fun    ALU with new operands
//     0xDD fun            ALU reusing held operands
//
//   Ports
//     CLK, REST        clock, synchronous active-high reset
//     rx_valid/rx_data received byte strobe and value
//     rf_wr_en/rf_rd_en/rf_addr/rf_wr_data   register-file side
//     alu_en/alu_fun/alu_op_a/alu_op_b       ALU side
//     frame_err        one-cycle pulse on bad command or inter-byte timeout
//     busy             high while a frame is in progress
//   Every output is registered.
module rx_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  REST,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  alu_en,
  output logic [3:0]            alu_fun,
  output logic [DATA_WIDTH-1:0] alu_op_a,
  output logic [DATA_WIDTH-1:0] alu_op_b,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_HLD = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    ALU_OPA = 3'd4,
    ALU_OPB = 3'd5,
    ALU_FUN = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   opa_q, opa_d;
  logic [DATA_WIDTH-1:0]   opb_q, opb_d;
  logic [3:0]              fun_q, fun_d;
  logic                    wr_q, wr_d;
  logic                    rd_q, rd_d;
  logic                    alu_q, alu_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    fun_d   = fun_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    alu_d   = 1'b0;
    err_d   = 1'b0;

    if (rx_valid) begin
      // An accepted byte always wins over a coincident timeout.
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (rx_data == CMD_WR)       state_d = WR_ADDR;
          else if (rx_data == CMD_RD)  state_d = RD_ADDR;
          else if (rx_data == CMD_ALU) state_d = ALU_OPA;
          else if (rx_data == CMD_HLD) state_d = ALU_FUN;
          else                         err_d   = 1'b1;
        end
        WR_ADDR: begin
          addr_d  = rx_data[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
        WR_DATA: begin
          wdata_d = rx_data;
          wr_d    = 1'b1;
          state_d = IDLE;
        end
        RD_ADDR: begin
          addr_d  = rx_data[ADDR_WIDTH-1:0];
          rd_d    = 1'b1;
          state_d = IDLE;
        end
        ALU_OPA: begin
          opa_d   = rx_data;
          state_d = ALU_OPB;
        end
        ALU_OPB: begin
          opb_d   = rx_data;
          state_d = ALU_FUN;
        end
        ALU_FUN: begin
          fun_d   = rx_data[3:0];
          alu_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Inter-byte silence too long: drop the frame without any strobe.
      state_d = IDLE;
      err_d   = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // Registered from the next state so busy tracks the state register.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (REST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      fun_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      alu_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      fun_q   <= fun_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_wr_en   = wr_q;
  assign rf_rd_en   = rd_q;
  assign rf_addr    = addr_q;
  assign rf_wr_data = wdata_q;
  assign alu_en     = alu_q;
  assign alu_fun    = fun_q;
  assign alu_op_a   = opa_q;
  assign alu_op_b   = opb_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Bench for rx_cmd_decoder: directed frames followed by randomized traffic,
// all compared against a frame-buffer reference model.
module tb_rx_cmd_decoder;

  localparam int T = 255;

  logic       CLK = 1'b0;
  logic       REST = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rf_wr_en, rf_rd_en, alu_en, frame_err, busy;
  logic [3:0] rf_addr, alu_fun;
  logic [7:0] rf_wr_data, alu_op_a, alu_op_b;

  rx_cmd_decoder #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK       (CLK),
    .REST      (REST),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rf_wr_en  (rf_wr_en),
    .rf_rd_en  (rf_rd_en),
    .rf_addr   (rf_addr),
    .rf_wr_data(rf_wr_data),
    .alu_en    (alu_en),
    .alu_fun   (alu_fun),
    .alu_op_a  (alu_op_a),
    .alu_op_b  (alu_op_b),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: collects the bytes of the current frame and applies
  // each byte's effect by (command, position) lookup.
  logic [7:0] fr[$];
  int         silent = 0;
  logic       e_wr = 0, e_rd = 0, e_alu = 0, e_err = 0, e_busy = 0;
  logic [3:0] e_addr = 0, e_fun = 0;
  logic [7:0] e_wd = 0, e_a = 0, e_b = 0;

  function automatic int frame_len(input logic [7:0] c);
    case (c)
      8'hAA:   return 3;
      8'hBB:   return 2;
      8'hCC:   return 4;
      8'hDD:   return 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    int idx;
    e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0;
    if (r) begin
      fr.delete();
      silent = 0;
      e_addr = 0; e_fun = 0; e_wd = 0; e_a = 0; e_b = 0;
    end else if (v) begin
      silent = 0;
      if (fr.size() == 0 && frame_len(d) == 0) begin
        e_err = 1;
      end else begin
        fr.push_back(d);
        idx = fr.size() - 1;
        case ({fr[0], idx[7:0]})
          {8'hAA, 8'd1}: e_addr = d[3:0];
          {8'hAA, 8'd2}: begin e_wd = d; e_wr = 1; end
          {8'hBB, 8'd1}: begin e_addr = d[3:0]; e_rd = 1; end
          {8'hCC, 8'd1}: e_a = d;
          {8'hCC, 8'd2}: e_b = d;
          {8'hCC, 8'd3}: begin e_fun = d[3:0]; e_alu = 1; end
          {8'hDD, 8'd1}: begin e_fun = d[3:0]; e_alu = 1; end
          default: ;
        endcase
        if (fr.size() == frame_len(fr[0])) fr.delete();
      end
    end else if (fr.size() != 0) begin
      silent++;
      if (silent > T) begin
        e_err = 1;
        fr.delete();
        silent = 0;
      end
    end
    e_busy = (fr.size() != 0);
  endtask

  task automatic check_all();
    chk("rf_wr_en",   {31'd0, rf_wr_en},  {31'd0, e_wr});
    chk("rf_rd_en",   {31'd0, rf_rd_en},  {31'd0, e_rd});
    chk("alu_en",     {31'd0, alu_en},    {31'd0, e_alu});
    chk("frame_err",  {31'd0, frame_err}, {31'd0, e_err});
    chk("busy",       {31'd0, busy},      {31'd0, e_busy});
    chk("rf_addr",    {28'd0, rf_addr},   {28'd0, e_addr});
    chk("rf_wr_data", {24'd0, rf_wr_data}, {24'd0, e_wd});
    chk("alu_fun",    {28'd0, alu_fun},   {28'd0, e_fun});
    chk("alu_op_a",   {24'd0, alu_op_a},  {24'd0, e_a});
    chk("alu_op_b",   {24'd0, alu_op_b},  {24'd0, e_b});
    chk("strobe_excl", {30'd0, 2'(rf_wr_en) + 2'(rf_rd_en) + 2'(alu_en) <= 2'd1}, 32'd1);
  endtask

  // Drive one cycle (inputs set away from the rising edge), then compare.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d);
    REST = r; rx_valid = v; rx_data = d;
    model_step(r, v, d);
    @(negedge CLK);
    check_all();
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  logic [7:0] cmds[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    @(negedge CLK);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {28'd0, rf_addr}, 32'd0);

    // Write frame
    send(8'hAA); send(8'h13); send(8'h5C);
    chk("wr_pulse", {31'd0, rf_wr_en}, 32'd1);
    chk("wr_addr",  {28'd0, rf_addr}, 32'h3);
    chk("wr_data",  {24'd0, rf_wr_data}, 32'h5C);
    idle(1);
    chk("wr_once",  {31'd0, rf_wr_en}, 32'd0);

    // Read frame then ALU frame, back to back
    send(8'hBB); send(8'h07);
    chk("rd_pulse", {31'd0, rf_rd_en}, 32'd1);
    chk("rd_addr",  {28'd0, rf_addr}, 32'h7);
    send(8'hCC); send(8'h09); send(8'h04); send(8'h02);
    chk("alu_pulse", {31'd0, alu_en}, 32'd1);
    chk("alu_a",     {24'd0, alu_op_a}, 32'h09);
    chk("alu_b",     {24'd0, alu_op_b}, 32'h04);
    chk("alu_fun",   {28'd0, alu_fun}, 32'h2);

    // Held operands
    send(8'hDD); send(8'h01);
    chk("hold_pulse", {31'd0, alu_en}, 32'd1);
    chk("hold_fun",   {28'd0, alu_fun}, 32'h1);
    chk("hold_a",     {24'd0, alu_op_a}, 32'h09);
    chk("hold_b",     {24'd0, alu_op_b}, 32'h04);

    // Bad command
    send(8'h55);
    chk("bad_err",  {31'd0, frame_err}, 32'd1);
    chk("bad_busy", {31'd0, busy}, 32'd0);
    idle(1);
    chk("bad_once", {31'd0, frame_err}, 32'd0);

    // Timeout: counter reaches T after T silent cycles, fires on the next
    send(8'hAA);
    idle(T);
    chk("to_pre_busy", {31'd0, busy}, 32'd1);
    chk("to_pre_err",  {31'd0, frame_err}, 32'd0);
    idle(1);
    chk("to_err",  {31'd0, frame_err}, 32'd1);
    chk("to_busy", {31'd0, busy}, 32'd0);
    idle(2);

    // A byte landing exactly on the timeout cycle is accepted
    send(8'hAA);
    idle(T);
    send(8'h0E);
    chk("to_edge_err",  {31'd0, frame_err}, 32'd0);
    chk("to_edge_busy", {31'd0, busy}, 32'd1);
    send(8'hA7);
    chk("to_edge_wr",   {31'd0, rf_wr_en}, 32'd1);
    chk("to_edge_addr", {28'd0, rf_addr}, 32'hE);

    // Reset mid-frame
    send(8'hCC); send(8'h11);
    cyc(1'b1, 1'b0, 8'h00);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_a",    {24'd0, alu_op_a}, 32'd0);
    chk("mid_rst_err",  {31'd0, frame_err}, 32'd0);
    send(8'hBB); send(8'h02);
    chk("post_rst_rd",   {31'd0, rf_rd_en}, 32'd1);
    chk("post_rst_addr", {28'd0, rf_addr}, 32'h2);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int sel;
      logic [7:0] d;
      if ($urandom_range(0, 299) == 0) begin
        cyc(1'b1, 1'b0, 8'h00);
      end else if ($urandom_range(0, 599) == 0) begin
        idle(T - 1 + int'($urandom_range(0, 3)));
      end else begin
        sel = int'($urandom_range(0, 7));
        d = (sel < 4) ? cmds[sel] : 8'($urandom_range(0, 255));
        cyc(1'b0, $urandom_range(0, 2) != 0, d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
